// File: rtl/varint_field_sched.sv
// Protobuf varint field scheduler: queues field descriptors and drives the varint
// serializer twice per field (value, then tag), writing downward from a cursor.
module varint_field_sched #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic [63:0]      cfg_base_addr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [28:0]      in_field_num,
  input  logic [4:0]       in_field_type,
  input  logic [63:0]      in_value,
  output logic             ser_en,
  output logic [63:0]      ser_dst_addr,
  output logic [63:0]      ser_value,
  output logic [4:0]       ser_field_type,
  input  logic             ser_done,
  input  logic [3:0]       ser_bytes_written,
  output logic [63:0]      cur_addr,
  output logic [CNT_W-1:0] total_bytes,
  output logic             field_done,
  output logic             err_type,
  output logic             busy
);

  localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W   = PTR_W + 1;
  localparam logic [4:0]  TAG_TYPE = 5'd13;

  typedef struct packed {
    logic [28:0] field_num;
    logic [4:0]  field_type;
    logic [63:0] value;
  } desc_t;

  typedef enum logic [2:0] {IDLE, VAL_RUN, VAL_GAP, TAG_RUN, TAG_GAP} state_t;

  desc_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [FCNT_W-1:0]  fifo_cnt;
  logic [FCNT_W-1:0]  fifo_cnt_d;
  desc_t              head;
  logic [28:0]        cur_field_num;
  state_t             state;
  state_t             state_d;
  logic               push;
  logic               pop;
  logic               load_val;
  logic               load_tag;
  logic               advance;
  logic               err_d;
  logic               done_d;
  logic               cfg_ok;

  function automatic logic legal_type(input logic [4:0] t);
    case (t)
      5'd3, 5'd4, 5'd5, 5'd8, 5'd13, 5'd14, 5'd17, 5'd18: legal_type = 1'b1;
      default:                                          legal_type = 1'b0;
    endcase
  endfunction

  assign head       = fifo_mem[rd_ptr];
  assign push       = in_valid & in_ready;
  assign cfg_ok     = cfg_start & ~busy;
  assign fifo_cnt_d = fifo_cnt + FCNT_W'(push) - FCNT_W'(pop);

  // Next-state and per-cycle control decode
  always_comb begin
    state_d  = state;
    pop      = 1'b0;
    load_val = 1'b0;
    load_tag = 1'b0;
    advance  = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_cnt != '0) begin
          pop = 1'b1;
          if (legal_type(head.field_type)) begin
            load_val = 1'b1;
            state_d  = VAL_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      VAL_RUN: begin
        if (ser_done) begin
          advance = 1'b1;
          state_d = VAL_GAP;
        end
      end
      VAL_GAP: begin
        load_tag = 1'b1;
        state_d  = TAG_RUN;
      end
      TAG_RUN: begin
        if (ser_done) begin
          advance = 1'b1;
          done_d  = 1'b1;
          state_d = TAG_GAP;
        end
      end
      TAG_GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Descriptor storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{field_num: in_field_num, field_type: in_field_type, value: in_value};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_cnt       <= '0;
      in_ready       <= 1'b0;
      busy           <= 1'b0;
      err_type       <= 1'b0;
      field_done     <= 1'b0;
      cur_field_num  <= '0;
      ser_en         <= 1'b0;
      ser_dst_addr   <= '0;
      ser_value      <= '0;
      ser_field_type <= '0;
      cur_addr       <= '0;
      total_bytes    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt   <= fifo_cnt_d;
      in_ready   <= (fifo_cnt_d != FCNT_W'(FIFO_DEPTH));
      busy       <= (fifo_cnt_d != '0) || (state_d != IDLE);
      err_type   <= err_d;
      field_done <= done_d;
      if (load_val) begin
        cur_field_num  <= head.field_num;
        ser_en         <= 1'b1;
        ser_dst_addr   <= cur_addr;
        ser_value      <= head.value;
        ser_field_type <= head.field_type;
      end
      // Tag is protobuf wire type 0 with the field number above it
      if (load_tag) begin
        ser_en         <= 1'b1;
        ser_dst_addr   <= cur_addr;
        ser_value      <= {32'b0, cur_field_num, 3'b000};
        ser_field_type <= TAG_TYPE;
      end
      if (advance) begin
        ser_en      <= 1'b0;
        cur_addr    <= cur_addr - 64'(ser_bytes_written);
        total_bytes <= total_bytes + CNT_W'(ser_bytes_written);
      end
      if (cfg_ok) begin
        cur_addr    <= cfg_base_addr;
        total_bytes <= '0;
      end
    end
  end

endmodule

// File: tb/tb_varint_field_sched.sv
// Self-checking bench for varint_field_sched: table of field descriptors, behavioural
// serializer responder, and a scoreboard of expected serializer invocations.
module tb_varint_field_sched;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_start = 1'b0;
  logic [63:0]      cfg_base_addr = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [28:0]      in_field_num = '0;
  logic [4:0]       in_field_type = '0;
  logic [63:0]      in_value = '0;
  logic             ser_en;
  logic [63:0]      ser_dst_addr;
  logic [63:0]      ser_value;
  logic [4:0]       ser_field_type;
  logic             ser_done = 1'b0;
  logic [3:0]       ser_bytes_written = '0;
  logic [63:0]      cur_addr;
  logic [CNT_W-1:0] total_bytes;
  logic             field_done;
  logic             err_type;
  logic             busy;

  varint_field_sched #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_field_num(in_field_num),
    .in_field_type(in_field_type), .in_value(in_value), .ser_en(ser_en),
    .ser_dst_addr(ser_dst_addr), .ser_value(ser_value), .ser_field_type(ser_field_type),
    .ser_done(ser_done), .ser_bytes_written(ser_bytes_written), .cur_addr(cur_addr),
    .total_bytes(total_bytes), .field_done(field_done), .err_type(err_type), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [28:0] fn;
    logic [4:0]  ty;
    logic [63:0] val;
    int          vb;
    int          tb;
    bit          legal;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] val;
    logic [4:0]  ty;
  } run_t;

  vec_t        vecs [14];
  run_t        sb_q [$];
  int          checks = 0;
  int          failures = 0;
  logic [63:0] m_cur = '0;
  logic [63:0] m_total = '0;
  int          fd_cnt = 0;
  int          err_cnt = 0;
  int          run_cnt = 0;
  bit          ser_hold = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Encoded varint length as a real serializer would produce for each type code
  function automatic int vlen(input logic [63:0] v, input logic [4:0] t);
    logic [63:0] e;
    int n;
    case (t)
      5'd5, 5'd14: e = {{32{v[31]}}, v[31:0]};
      5'd13:       e = {32'b0, v[31:0]};
      5'd8:        e = {63'b0, |v};
      5'd17:       e = {32'b0, (v[31:0] << 1) ^ {32{v[31]}}};
      5'd18:       e = (v << 1) ^ {64{v[63]}};
      default:     e = v;
    endcase
    n = 1;
    while (e >= 64'd128) begin
      e = e >> 7;
      n++;
    end
    return n;
  endfunction

  function automatic vec_t mk(input logic [28:0] fn, input logic [4:0] ty, input logic [63:0] val,
                              input int vb, input int tb, input bit legal);
    vec_t v;
    v.fn = fn; v.ty = ty; v.val = val; v.vb = vb; v.tb = tb; v.legal = legal;
    return v;
  endfunction

  // Output monitor: counts pulses and checks each serializer run against the scoreboard
  bit prev_en = 1'b0;
  always @(negedge clk) begin
    run_t r;
    if (!reset) begin
      fd_cnt  += int'(field_done);
      err_cnt += int'(err_type);
      if (ser_en && !prev_en) begin
        run_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_run: got ser_en with type %0d, expected no run", ser_field_type);
        end else begin
          r = sb_q.pop_front();
          chk("ser_dst_addr", ser_dst_addr, r.addr);
          chk("ser_value", ser_value, r.val);
          chk("ser_field_type", 64'(ser_field_type), 64'(r.ty));
        end
      end
    end
    prev_en = ser_en;
  end

  // Serializer model: random latency, then a one-cycle ser_done with the encoded length
  bit          pend = 1'b0;
  int          lat = 0;
  logic [63:0] cap_addr;
  logic [63:0] cap_val;
  always @(negedge clk) begin
    ser_done = 1'b0;
    if (!ser_en) begin
      pend = 1'b0;
    end else if (!pend) begin
      pend     = 1'b1;
      lat      = $urandom_range(1, 3);
      cap_addr = ser_dst_addr;
      cap_val  = ser_value;
    end else if (lat > 0) begin
      lat--;
    end else if (!ser_hold) begin
      chk("ser_addr_stable", ser_dst_addr, cap_addr);
      chk("ser_value_stable", ser_value, cap_val);
      ser_done          = 1'b1;
      ser_bytes_written = 4'(vlen(ser_value, ser_field_type));
      lat               = 100000;
    end
  end

  task automatic do_cfg(input logic [63:0] base, input bit expect_taken);
    @(negedge clk);
    cfg_start     = 1'b1;
    cfg_base_addr = base;
    @(posedge clk);
    #1 cfg_start = 1'b0;
    if (expect_taken) begin
      m_cur   = base;
      m_total = '0;
    end
  endtask

  task automatic push(input int idx);
    bit ok;
    vec_t v;
    v = vecs[idx];
    in_field_num  = v.fn;
    in_field_type = v.ty;
    in_value      = v.val;
    in_valid      = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: vector %0d got in_ready=0 expected 1", idx);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (v.legal) begin
      sb_q.push_back('{addr: m_cur, val: v.val, ty: v.ty});
      m_cur = m_cur - 64'(v.vb);
      sb_q.push_back('{addr: m_cur, val: {32'b0, v.fn, 3'b000}, ty: 5'd13});
      m_cur   = m_cur - 64'(v.tb);
      m_total = m_total + 64'(v.vb + v.tb);
    end
  endtask

  task automatic wait_idle(input string name);
    repeat (3) @(negedge clk);
    for (int c = 0; c < 2000; c++) begin
      if (!busy) return;
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL %s_idle_timeout: got busy=1 expected 0", name);
  endtask

  task automatic check_totals(input string name);
    chk({name, "_cur_addr"}, cur_addr, m_cur);
    chk({name, "_total"}, 64'(total_bytes), 64'(m_total[CNT_W-1:0]));
    chk({name, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
  endtask

  int fd0;
  int err0;
  int run0;

  initial begin
    vecs[0]  = mk(29'd1,         5'd4,  64'd300,        2,  1, 1'b1);
    vecs[1]  = mk(29'd2,         5'd17, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1'b1);
    vecs[2]  = mk(29'd3,         5'd5,  64'd1,          1,  1, 1'b1);
    vecs[3]  = mk(29'd4,         5'd13, 64'd128,        2,  1, 1'b1);
    vecs[4]  = mk(29'd16,        5'd18, 64'hFFFF_FFFF_FFFF_FFFE, 1, 2, 1'b1);
    vecs[5]  = mk(29'd5,         5'd8,  64'd1,          1,  1, 1'b1);
    vecs[6]  = mk(29'd6,         5'd14, 64'd150,        2,  1, 1'b1);
    vecs[7]  = mk(29'd7,         5'd3,  64'hFFFF_FFFF_FFFF_FFFF, 10, 1, 1'b1);
    vecs[8]  = mk(29'd8,         5'd1,  64'd5,          0,  0, 1'b0);
    vecs[9]  = mk(29'd9,         5'd4,  64'd0,          1,  1, 1'b1);
    vecs[10] = mk(29'd536870911, 5'd4,  64'hFFFF_FFFF_FFFF_FFFF, 10, 5, 1'b1);
    vecs[11] = mk(29'd10,        5'd4,  64'd1,          1,  1, 1'b1);
    vecs[12] = mk(29'd11,        5'd4,  64'd16384,      3,  1, 1'b1);
    vecs[13] = mk(29'd12,        5'd4,  64'd2,          1,  1, 1'b1);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ser_en", 64'(ser_en), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cur_addr", cur_addr, 64'd0);
    chk("rst_total", 64'(total_bytes), 64'd0);
    chk("rst_field_done", 64'(field_done), 64'd0);
    chk("rst_err_type", 64'(err_type), 64'd0);
    chk("rst_ser_dst_addr", ser_dst_addr, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // T1: uint64 300 in field 1
    do_cfg(64'h1000, 1'b1);
    fd0 = fd_cnt;
    push(0);
    wait_idle("t1");
    check_totals("t1");
    chk("t1_cur_const", cur_addr, 64'h0FFD);
    chk("t1_total_const", 64'(total_bytes), 64'd3);
    chk("t1_field_done", 64'(fd_cnt - fd0), 64'd1);

    // T2: sint32 -1 in field 2
    do_cfg(64'h2000, 1'b1);
    push(1);
    wait_idle("t2");
    check_totals("t2");
    chk("t2_total_const", 64'(total_bytes), 64'd2);

    // T3: five back-to-back with the serializer stalled, plus an ignored cfg_start
    do_cfg(64'h3000, 1'b1);
    fd0 = fd_cnt;
    ser_hold = 1'b1;
    for (int i = 2; i <= 6; i++) push(i);
    @(negedge clk);
    chk("t3_in_ready_full", 64'(in_ready), 64'd0);
    chk("t3_busy", 64'(busy), 64'd1);
    do_cfg(64'hDEAD_0000, 1'b0);
    ser_hold = 1'b0;
    wait_idle("t3");
    check_totals("t3");
    chk("t3_field_done", 64'(fd_cnt - fd0), 64'd5);
    chk("t3_in_ready_after", 64'(in_ready), 64'd1);

    // T4: illegal type between legal neighbours
    do_cfg(64'h4000, 1'b1);
    fd0  = fd_cnt;
    err0 = err_cnt;
    run0 = run_cnt;
    for (int i = 7; i <= 9; i++) push(i);
    wait_idle("t4");
    check_totals("t4");
    chk("t4_err_type", 64'(err_cnt - err0), 64'd1);
    chk("t4_field_done", 64'(fd_cnt - fd0), 64'd2);
    chk("t4_runs", 64'(run_cnt - run0), 64'd4);

    // T5: maximal field number and value
    do_cfg(64'h5000, 1'b1);
    push(10);
    wait_idle("t5");
    check_totals("t5");
    chk("t5_cur_const", cur_addr, 64'h4FF1);
    chk("t5_total_const", 64'(total_bytes), 64'd15);

    // T6: reset while the tag run is waiting for ser_done
    do_cfg(64'h6000, 1'b1);
    run0 = run_cnt;
    push(11);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (run_cnt >= run0 + 2) break;
    end
    ser_hold = 1'b1;
    chk("t6_reached_tag_run", 64'(run_cnt - run0), 64'd2);
    repeat (2) @(negedge clk);
    chk("t6_tag_running", 64'(ser_en), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_ser_en", 64'(ser_en), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_cur_addr", cur_addr, 64'd0);
    reset    = 1'b0;
    ser_hold = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    do_cfg(64'h8000, 1'b1);
    fd0 = fd_cnt;
    push(12);
    push(13);
    wait_idle("t6");
    check_totals("t6");
    chk("t6_total_const", 64'(total_bytes), 64'd6);
    chk("t6_field_done", 64'(fd_cnt - fd0), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so a stuck design still reaches the summary
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
